// File: rtl/pipe_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_arbiter
//   Shares one fixed-latency, unstallable arithmetic pipe between two
//   requesters (A = index 0, B = index 1). Issue is round-robin arbitrated.
//   A tag shift register follows each operation down the pipe so its result
//   can be steered into the originating requester's response FIFO. Each
//   requester holds DEPTH credits. An op consumes a credit at issue and returns
//   it when its response is popped, so a FIFO can never overflow even though
//   the pipe cannot be stalled.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   a_valid/a_ready/a_x/a_y     requester A issue handshake and operands
//   a_rsp_valid/a_rsp_ready     requester A response handshake
//   a_rsp_add_sqr/a_rsp_out     requester A results (x+y)^2 and x^2-1
//   b_*                         same set of signals for requester B
//   pipe_x/pipe_y               operands driven into the shared pipe
//   pipe_add_sqr/pipe_out       pipe results, LAT edges after pipe_x/pipe_y
//   idle                        nothing in flight and both FIFOs empty
// -----------------------------------------------------------------------------
module pipe_arbiter #(
  parameter int W     = 8,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [W-1:0]   a_x,
  input  logic [W-1:0]   a_y,
  output logic           a_rsp_valid,
  input  logic           a_rsp_ready,
  output logic [2*W+1:0] a_rsp_add_sqr,
  output logic [2*W-1:0] a_rsp_out,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [W-1:0]   b_x,
  input  logic [W-1:0]   b_y,
  output logic           b_rsp_valid,
  input  logic           b_rsp_ready,
  output logic [2*W+1:0] b_rsp_add_sqr,
  output logic [2*W-1:0] b_rsp_out,
  output logic [W-1:0]   pipe_x,
  output logic [W-1:0]   pipe_y,
  input  logic [2*W+1:0] pipe_add_sqr,
  input  logic [2*W-1:0] pipe_out,
  output logic           idle
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = 2 * W + 2;
  localparam int OW = 2 * W;
  localparam int RW = AW + OW;

  logic [1:0]     w_valid;
  logic [1:0]     w_rsp_ready;
  logic [1:0]     w_elig;
  logic [1:0]     w_grant;
  logic [1:0]     w_push;
  logic [1:0]     w_pop;
  logic [1:0]     w_nonempty;
  logic [RW-1:0]  w_head [2];

  logic           r_last_b;   // 1 = B was granted most recently
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_id;   // 0 = A, 1 = B

  assign w_valid     = {b_valid, a_valid};
  assign w_rsp_ready = {b_rsp_ready, a_rsp_ready};

  // Grant: a lone eligible requester wins. On a tie the one not granted last
  // wins. Nothing is granted while reset is held.
  always_comb begin
    w_grant = 2'b00;
    if (!rst) begin
      if (&w_elig) begin
        w_grant = r_last_b ? 2'b01 : 2'b10;
      end else begin
        w_grant = w_elig;
      end
    end
  end

  always_comb begin
    pipe_x = '0;
    pipe_y = '0;
    if (w_grant[0]) begin
      pipe_x = a_x;
      pipe_y = a_y;
    end else if (w_grant[1]) begin
      pipe_x = b_x;
      pipe_y = b_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (|w_grant) begin
      r_last_b <= w_grant[1];
    end
  end

  // The tag line mirrors the pipe's stages one for one. A valid tag at the
  // last stage owns the result currently on pipe_add_sqr/pipe_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= |w_grant;
      r_tag_id[0]  <= w_grant[1];
      for (int k = 1; k < LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  assign w_push[0] = r_tag_vld[LAT-1] & ~r_tag_id[LAT-1];
  assign w_push[1] = r_tag_vld[LAT-1] &  r_tag_id[LAT-1];

  // Per-requester response FIFO and credit counter.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [RW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_credit;

    assign w_nonempty[gi] = (r_count != '0);
    assign w_pop[gi]      = w_nonempty[gi] & w_rsp_ready[gi] & ~rst;
    assign w_elig[gi]     = w_valid[gi] & (r_credit != '0);
    assign w_head[gi]     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
      if (w_push[gi]) begin
        r_mem[r_wr_ptr] <= {pipe_add_sqr, pipe_out};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_credit <= CW'(DEPTH);
      end else begin
        if (w_push[gi]) begin
          r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        end
        if (w_pop[gi]) begin
          r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        end
        r_count  <= r_count + CW'(w_push[gi]) - CW'(w_pop[gi]);
        // A credit leaves at issue and comes back when the response is popped.
        r_credit <= r_credit - CW'(w_grant[gi]) + CW'(w_pop[gi]);
      end
    end
  end

  assign a_ready       = w_grant[0];
  assign b_ready       = w_grant[1];
  assign a_rsp_valid   = w_nonempty[0] & ~rst;
  assign b_rsp_valid   = w_nonempty[1] & ~rst;
  assign a_rsp_add_sqr = w_head[0][RW-1:OW];
  assign a_rsp_out     = w_head[0][OW-1:0];
  assign b_rsp_add_sqr = w_head[1][RW-1:OW];
  assign b_rsp_out     = w_head[1][OW-1:0];
  assign idle          = rst | ~((|r_tag_vld) | (|w_nonempty));

endmodule

// File: tb/tb_pipe_arbiter.sv
module tb_pipe_arbiter;
  localparam int W     = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           a_valid, a_ready, a_rsp_valid, a_rsp_ready;
  logic [W-1:0]   a_x, a_y;
  logic [2*W+1:0] a_rsp_add_sqr;
  logic [2*W-1:0] a_rsp_out;
  logic           b_valid, b_ready, b_rsp_valid, b_rsp_ready;
  logic [W-1:0]   b_x, b_y;
  logic [2*W+1:0] b_rsp_add_sqr;
  logic [2*W-1:0] b_rsp_out;
  logic [W-1:0]   pipe_x, pipe_y;
  logic [2*W+1:0] pipe_add_sqr;
  logic [2*W-1:0] pipe_out;
  logic           idle;

  always #5 clk = ~clk;

  pipe_arbiter #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
    .a_rsp_add_sqr(a_rsp_add_sqr), .a_rsp_out(a_rsp_out),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
    .b_rsp_add_sqr(b_rsp_add_sqr), .b_rsp_out(b_rsp_out),
    .pipe_x(pipe_x), .pipe_y(pipe_y),
    .pipe_add_sqr(pipe_add_sqr), .pipe_out(pipe_out),
    .idle(idle)
  );

  // Shared arithmetic pipe: fixed LAT-edge latency, no valid, no stall.
  logic [2*W+1:0] p_add [LAT];
  logic [2*W-1:0] p_out [LAT];
  logic [2*W+1:0] p_sum;
  assign p_sum = (2*W+2)'(pipe_x) + (2*W+2)'(pipe_y);
  always @(posedge clk) begin
    p_add[0] <= p_sum * p_sum;
    p_out[0] <= (2*W)'(pipe_x) * (2*W)'(pipe_x) - (2*W)'(1);
    for (int k = 1; k < LAT; k++) begin
      p_add[k] <= p_add[k-1];
      p_out[k] <= p_out[k-1];
    end
  end
  assign pipe_add_sqr = p_add[LAT-1];
  assign pipe_out     = p_out[LAT-1];

  // Reference model: one queue of outstanding ops per requester (issued but
  // not yet popped). Credit = DEPTH - outstanding. An op's response becomes
  // visible LAT+1 cycles after its issue cycle.
  typedef struct {
    int add_sqr;
    int out;
    int t_rdy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cycle    = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   last_b   = 1'b1;

  function automatic exp_t make_exp(input int x, input int y, input int t);
    exp_t e;
    e.add_sqr = (x + y) * (x + y);
    e.out     = (x * x - 1) & ((1 << (2 * W)) - 1);
    e.t_rdy   = t + LAT + 1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic cyc(input bit av, input int ax, input int ay, input bit ar,
                     input bit bv, input int bx, input int by, input bit br);
    bit ea, eb, ga, gb, va, vb;
    int ex, ey;
    a_valid = av; a_x = W'(ax); a_y = W'(ay); a_rsp_ready = ar;
    b_valid = bv; b_x = W'(bx); b_y = W'(by); b_rsp_ready = br;
    ea = av && (qa.size() < DEPTH);
    eb = bv && (qb.size() < DEPTH);
    ga = ea && (!eb || last_b);
    gb = eb && (!ea || !last_b);
    va = (qa.size() > 0) && (qa[0].t_rdy <= cycle);
    vb = (qb.size() > 0) && (qb[0].t_rdy <= cycle);
    ex = ga ? ax : (gb ? bx : 0);
    ey = ga ? ay : (gb ? by : 0);
    #4;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("pipe_x", pipe_x, ex);
    chk("pipe_y", pipe_y, ey);
    chk("a_rsp_valid", a_rsp_valid, va);
    chk("b_rsp_valid", b_rsp_valid, vb);
    if (va) begin
      chk("a_rsp_add_sqr", a_rsp_add_sqr, qa[0].add_sqr);
      chk("a_rsp_out", a_rsp_out, qa[0].out);
    end
    if (vb) begin
      chk("b_rsp_add_sqr", b_rsp_add_sqr, qb[0].add_sqr);
      chk("b_rsp_out", b_rsp_out, qb[0].out);
    end
    chk("idle", idle, (qa.size() == 0) && (qb.size() == 0));
    @(posedge clk);
    if (va && ar) begin
      $display("cycle %0d: resp A add_sqr=%0d out=%0d", cycle, qa[0].add_sqr, qa[0].out);
      void'(qa.pop_front());
    end
    if (vb && br) begin
      $display("cycle %0d: resp B add_sqr=%0d out=%0d", cycle, qb[0].add_sqr, qb[0].out);
      void'(qb.pop_front());
    end
    if (ga) begin
      qa.push_back(make_exp(ax, ay, cycle));
      $display("cycle %0d: issue A x=%0d y=%0d", cycle, ax, ay);
    end
    if (gb) begin
      qb.push_back(make_exp(bx, by, cycle));
      $display("cycle %0d: issue B x=%0d y=%0d", cycle, bx, by);
    end
    if (ga) last_b = 1'b0;
    else if (gb) last_b = 1'b1;
    cycle++;
    #1;
  endtask

  // One reset cycle with both requesters asserting valid, so gating is seen.
  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b1; a_x = 8'd5; a_y = 8'd6; a_rsp_ready = 1'b1;
    b_valid = 1'b1; b_x = 8'd7; b_y = 8'd8; b_rsp_ready = 1'b1;
    #4;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_a_rsp_valid", a_rsp_valid, 1'b0);
    chk("rst_b_rsp_valid", b_rsp_valid, 1'b0);
    chk("rst_pipe_x", pipe_x, 0);
    chk("rst_pipe_y", pipe_y, 0);
    chk("rst_idle", idle, 1'b1);
    @(posedge clk);
    $display("cycle %0d: reset", cycle);
    qa.delete();
    qb.delete();
    last_b = 1'b1;
    cycle++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_x = '0; a_y = '0; a_rsp_ready = 1'b0;
    b_valid = 1'b0; b_x = '0; b_y = '0; b_rsp_ready = 1'b0;
    do_reset();
    do_reset();

    // Single request from A.
    cyc(1, 3, 4, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);

    // Fair sharing: both valid every cycle.
    for (int i = 0; i < 8; i++)
      cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), 1,
          1, $urandom_range(0, 255), $urandom_range(0, 255), 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);

    // Backpressure on A: credits run out, then a pop returns one.
    for (int i = 0; i < 7; i++) cyc(1, i, i + 1, 0, 0, 0, 0, 0);
    cyc(1, 9, 9, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 10 + i, 1, 0, 0, 0, 0, 0);

    // A stuck at zero credit while B requests continuously.
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 2, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);

    // Reset with ops in flight.
    cyc(1, 1, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 2, 2, 1);
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);
    cyc(1, 20, 21, 1, 1, 22, 23, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 30 + i, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);

    // Width corners.
    cyc(1, 255, 255, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 3) != 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_arbiter.md
Name: pipe_arbiter

Overview:
- Shares one instance of the 3-stage arithmetic pipe (inputs x/y; outputs add_sqr = (x+y)^2 and out = x^2-1) between two requesters, A and B.
- Round-robin arbitration on issue. A tag shift register tracks each operation through the fixed-latency pipe, which has no valid or stall.
- Results return to the originating requester through a per-requester response FIFO.
- Credit-based flow control guarantees the FIFOs never overflow, so the unstallable pipe is always safe to drain.

Parameters:
- W, 8, operand width; must match the pipe's W.
- LAT, 3, pipe latency in clock edges from x/y to add_sqr/out.
- DEPTH, 4, entries per response FIFO; also the initial credit per requester.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- a_valid  input  1  A request valid.
- a_ready  output  1  A request accepted this cycle.
- a_x  input  W  A operand x.
- a_y  input  W  A operand y.
- a_rsp_valid  output  1  A response available.
- a_rsp_ready  input  1  A consumes the response.
- a_rsp_add_sqr  output  2W+2  A result (x+y)^2.
- a_rsp_out  output  2W  A result x^2-1.
- b_valid, b_ready, b_x, b_y, b_rsp_valid, b_rsp_ready, b_rsp_add_sqr, b_rsp_out: same as A, for requester B.
- pipe_x  output  W  to pipe x.
- pipe_y  output  W  to pipe y.
- pipe_add_sqr  input  2W+2  from pipe add_sqr.
- pipe_out  input  2W  from pipe out.
- idle  output  1  no op in flight and both FIFOs empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - Clears tag shift register and both FIFOs.
  - Sets credit_a = credit_b = DEPTH.
  - Sets the round-robin pointer to "B last granted", so A wins the first tie.
  - While rst=1: a_ready=b_ready=0, rsp_valid=0, pipe_x=pipe_y=0, idle=1.
  - Reset mid-operation discards in-flight ops; pipe outputs are ignored until new tags reach the end.
- Eligibility: a requester is eligible when valid=1 and credit>0.
- Grant:
  - Combinational, at most one per cycle.
  - With one eligible requester, grant it.
  - With two eligible requesters, grant the one not granted last.
  - The pointer updates only on a grant.
  - ready=1 only for the granted requester; no ready without valid.
- Issue:
  - pipe_x/pipe_y carry the granted requester's x/y; they are 0 when no grant.
  - At the edge, tag[0] <= {grant, id}.
  - tag[k] <= tag[k-1] for k = 1..LAT-1.
- Capture:
  - While tag[LAT-1] is valid, pipe_add_sqr/pipe_out belong to that op.
  - At the edge, they are pushed into FIFO[id].
  - Latency from the issue cycle t to rsp_valid is t+LAT+1 when the FIFO is empty.
- Response FIFO:
  - rsp_valid = not empty; data comes from the head register.
  - Pop on rsp_valid && rsp_ready.
  - Order is preserved per requester; requesters are independent of each other.
  - Push and pop may occur in the same cycle.
- Credit:
  - Decrement on issue; increment on pop.
  - Issue and pop in the same cycle leaves credit unchanged.
  - Invariant: credit + in-flight + FIFO occupancy = DEPTH, so the FIFO never overflows.
  - Credit=0 blocks that requester only. The other requester then receives grants every cycle it is valid.
- Arithmetic: the block passes data through unmodified, with no width change.
- idle = no tag valid AND both FIFOs empty (registered-state based).

Test Plan:
- Single request: A only, x=3, y=4, issued cycle t, a_rsp_ready=1.
  -> a_ready=1 at t; a_rsp_valid at t+4 with add_sqr=49, out=8; b_rsp_valid stays 0; idle=1 from t+5.
- Fair sharing: A and B valid every cycle for 8 cycles.
  -> grants A,B,A,B,A,B,A,B; each side gets 4 responses in issue order, with values correct per operands.
- Backpressure: a_rsp_ready=0, A valid continuously, B idle.
  -> exactly 4 A accepts, then a_ready=0.
  -> Then one pop -> exactly one more A accept.
  -> Pop and a new A request in the same cycle at credit 0 -> accept is still blocked that cycle and credit stays consistent.
- Starvation-free: A at credit 0, B valid continuously.
  -> B granted every cycle; no A grants.
- Reset mid-flight: issue A (x=1, y=1) and B (x=2, y=2), then rst=1 for one cycle at the next cycle.
  -> no response ever appears; credits return to 4; idle=1; the next tie goes to A.
- Width corners: A x=255, y=255 -> add_sqr=260100, out=65024. B x=0, y=0 -> add_sqr=0, out=16'hFFFF.
